// File: rtl/tick_gen.sv
// tick_gen: programmable periodic / one-shot tick generator.
// A counter runs from 0 up to period_r and emits a one-cycle tick on the
// edge where it wraps back to 0, so ticks are period_r+1 clocks apart.
// Control strobes, in priority order: stop, then start, then counting
// (which is gated by en). A period reload is independent of all of them.
module tick_gen #(
    parameter int unsigned       CNT_W          = 16,
    parameter logic [CNT_W-1:0]  DEFAULT_PERIOD = 16'd50000,
    parameter bit                AUTOSTART      = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             one_shot,
    input  logic             period_load,
    input  logic [CNT_W-1:0] period_in,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic             mode_one_shot_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] period_r;
    logic             tick_r;
    logic             wrap_s;

    // A >= compare (not ==) lets a period lowered below the current count
    // wrap on the very next edge instead of running the counter to overflow.
    assign wrap_s = (count_r >= period_r);

    // Period register: reload accepted in any state and regardless of en.
    // The wrap compare on the same edge still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_r <= DEFAULT_PERIOD;
        end else if (period_load) begin
            period_r <= period_in;
        end else begin
            period_r <= period_r;
        end
    end

    // Control FSM, counter and tick pulse, all registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= AUTOSTART ? RUN : IDLE;
            mode_one_shot_r <= 1'b0;
            count_r         <= CNT_ZERO;
            tick_r          <= 1'b0;
        end else if (stop) begin
            // Abort wins over everything, including a simultaneous start.
            state_r <= IDLE;
            count_r <= CNT_ZERO;
            tick_r  <= 1'b0;
        end else if (start) begin
            // (Re)start: counting begins from 0, mode re-latched, no tick.
            state_r         <= RUN;
            mode_one_shot_r <= one_shot;
            count_r         <= CNT_ZERO;
            tick_r          <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (en) begin
                        if (wrap_s) begin
                            count_r <= CNT_ZERO;
                            tick_r  <= 1'b1;
                            state_r <= mode_one_shot_r ? IDLE : RUN;
                        end else begin
                            count_r <= count_r + CNT_ONE;
                            tick_r  <= 1'b0;
                        end
                    end else begin
                        // Paused: hold count and state, suppress tick.
                        tick_r <= 1'b0;
                    end
                end
                IDLE: begin
                    count_r <= CNT_ZERO;
                    tick_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= CNT_ZERO;
                    tick_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tick  = tick_r;
    assign count = count_r;
    assign busy  = (state_r == RUN);

endmodule

// File: tb/tb_tick_gen.sv
// Testbench for tick_gen: two instances (autostart / idle-at-reset) share
// stimulus. A driver pushes the reference model's expected outputs into a
// scoreboard queue; a monitor pops and compares after every rising edge.
module tb_tick_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        start;
    logic        stop;
    logic        one_shot;
    logic        period_load;
    logic [15:0] period_in;
    logic        tick1, busy1, tick2, busy2;
    logic [15:0] count1, count2;

    int n_checks = 0;
    int n_fail   = 0;

    tick_gen #(.CNT_W(16), .DEFAULT_PERIOD(16'd4), .AUTOSTART(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
        .one_shot(one_shot), .period_load(period_load), .period_in(period_in),
        .tick(tick1), .busy(busy1), .count(count1)
    );

    tick_gen #(.CNT_W(16), .DEFAULT_PERIOD(16'd7), .AUTOSTART(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
        .one_shot(one_shot), .period_load(period_load), .period_in(period_in),
        .tick(tick2), .busy(busy2), .count(count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: behaviour described as rules over an abstract timer.
    typedef struct packed {
        logic        run;
        logic        os;
        logic [15:0] cnt;
        logic        tick;
        logic [15:0] per;
    } mdl_t;

    typedef struct packed {
        logic        t1;
        logic        b1;
        logic [15:0] c1;
        logic        t2;
        logic        b2;
        logic [15:0] c2;
    } exp_t;

    mdl_t m1, m2;
    exp_t sb[$];

    localparam mdl_t M1_RST = '{run: 1'b1, os: 1'b0, cnt: 16'd0, tick: 1'b0, per: 16'd4};
    localparam mdl_t M2_RST = '{run: 1'b0, os: 1'b0, cnt: 16'd0, tick: 1'b0, per: 16'd7};

    function automatic mdl_t step(input mdl_t m, input logic e, input logic st,
                                  input logic sp, input logic os_i,
                                  input logic pl, input logic [15:0] pin);
        mdl_t n;
        n      = m;
        n.tick = 1'b0;
        if (pl) n.per = pin;
        if (sp) begin
            n.run = 1'b0;
            n.cnt = 16'd0;
        end else if (st) begin
            n.run = 1'b1;
            n.os  = os_i;
            n.cnt = 16'd0;
        end else if (m.run && e) begin
            if (int'(m.cnt) >= int'(m.per)) begin
                n.cnt  = 16'd0;
                n.tick = 1'b1;
                if (m.os) n.run = 1'b0;
            end else begin
                n.cnt = 16'(int'(m.cnt) + 1);
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, predict, enqueue.
    task automatic cyc(input logic e, input logic st, input logic sp,
                       input logic os, input logic pl, input logic [15:0] pin);
        en          = e;
        start       = st;
        stop        = sp;
        one_shot    = os;
        period_load = pl;
        period_in   = pin;
        m1 = step(m1, e, st, sp, os, pl, pin);
        m2 = step(m2, e, st, sp, os, pl, pin);
        sb.push_back('{m1.tick, m1.run, m1.cnt, m2.tick, m2.run, m2.cnt});
        @(negedge clk);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_tick1", 32'(tick1), 32'd0);
        chk("rst_count1", 32'(count1), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd1);
        chk("rst_tick2", 32'(tick2), 32'd0);
        chk("rst_count2", 32'(count2), 32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);
        en = 1'b0; start = 1'b0; stop = 1'b0; one_shot = 1'b0;
        period_load = 1'b0; period_in = 16'd0;
        m1 = M1_RST;
        m2 = M2_RST;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare both instances against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_dut1", 32'({tick1, busy1, count1}), 32'({e.t1, e.b1, e.c1}));
                chk("sb_dut2", 32'({tick2, busy2, count2}), 32'({e.t2, e.b2, e.c2}));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en = 1'b0; start = 1'b0; stop = 1'b0; one_shot = 1'b0;
        period_load = 1'b0; period_in = 16'd0;
        m1 = M1_RST;
        m2 = M2_RST;
        @(negedge clk);
        apply_reset();

        // Autostart, period 4: ticks on edges 5, 10, 15, busy throughout.
        for (int k = 1; k <= 15; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
            chk("autostart_tick", 32'(tick1), 32'(k % 5 == 0));
            chk("autostart_busy", 32'(busy1), 32'd1);
        end

        // One-shot, period 3: single tick 4 clocks after start, then idle.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
            chk("oneshot_tick", 32'(tick1), 32'(k == 4));
            chk("oneshot_busy", 32'(busy1), 32'(k < 4));
        end
        chk("oneshot_count", 32'(count1), 32'd0);

        // Period lowered from 10 to 5 while count is 8.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd10);
        repeat (8) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        chk("lower_count8", 32'(count1), 32'd8);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5);
        chk("lower_oldper", 32'(tick1), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        chk("lower_wrap", 32'(tick1), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
            chk("lower_spacing", 32'(tick1), 32'(k % 6 == 0));
        end

        // Pause for 7 cycles at count 2, period 4.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd4);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int k = 0; k < 7; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
            chk("pause_count", 32'(count1), 32'd2);
            chk("pause_tick", 32'(tick1), 32'd0);
        end
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
            chk("resume_tick", 32'(tick1), 32'(k == 3 || k == 8));
        end

        // start and stop together in RUN: stop wins.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        chk("startstop_busy", 32'(busy1), 32'd0);
        chk("startstop_count", 32'(count1), 32'd0);
        chk("startstop_tick", 32'(tick1), 32'd0);

        // Period 0: tick continuously high, then async reset mid-pattern.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
            chk("per0_tick", 32'(tick1), 32'd1);
        end
        apply_reset();

        // Randomized traffic checked only by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) apply_reset();
            cyc(($urandom_range(0, 3) != 0),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 31) == 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0),
                16'($urandom_range(0, 12)));
        end

        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16; width of the counter, period register and period input.
REQ-002 SHALL have parameter DEFAULT_PERIOD, default 16'd50000; period_reg value at reset.
REQ-003 SHALL have parameter AUTOSTART, default 1; 1 = reset state RUN in periodic mode, 0 = reset state IDLE.
REQ-004 SHALL have port clk, input, 1 bit; single clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit; 1 = counting allowed, 0 = pause (all state held).
REQ-007 SHALL have port start, input, 1 bit; one-cycle strobe that starts or restarts counting.
REQ-008 SHALL have port stop, input, 1 bit; one-cycle strobe that aborts counting.
REQ-009 SHALL have port one_shot, input, 1 bit; sampled on start: 1 = single tick, 0 = periodic.
REQ-010 SHALL have port period_load, input, 1 bit; strobe that writes period_in into period_reg.
REQ-011 SHALL have port period_in, input, CNT_W bits; new period value.
REQ-012 SHALL have port tick, output, 1 bit; registered one-cycle pulse.
REQ-013 SHALL have port busy, output, 1 bit; 1 while in state RUN.
REQ-014 SHALL have port count, output, CNT_W bits; current counter value.

Function
REQ-015 SHALL implement two states: IDLE and RUN. A registered mode bit (periodic/one-shot) is latched from one_shot when RUN is entered via start.
REQ-016 In RUN with en=1, when count >= period_reg, the next edge SHALL set count to 0 and tick to 1. Otherwise count SHALL increment by 1 and tick SHALL be 0.
REQ-017 Tick spacing SHALL be period_reg+1 clocks; period_reg=0 SHALL give tick high on every RUN+en cycle.
REQ-018 The >= compare SHALL make a period lowered below the current count wrap at the next edge, with no counter overflow.
REQ-019 At a wrap in one-shot mode, the same edge SHALL move the state to IDLE. In periodic mode the state SHALL remain RUN.
REQ-020 In IDLE, tick SHALL be 0 and count SHALL be 0; start SHALL move the state to RUN with count=0 on the next edge.
REQ-021 start in RUN SHALL reset count to 0, re-latch the mode and suppress tick on that edge.
REQ-022 stop SHALL force IDLE, count=0 and tick=0 on the next edge, regardless of en.
REQ-023 stop SHALL take priority over start in the same cycle.
REQ-024 start SHALL act regardless of en; afterwards the counter stays at 0 until en=1.
REQ-025 When en=0, the block SHALL hold count and state and force tick=0; counting SHALL resume from the held count when en returns to 1.
REQ-026 period_load SHALL update period_reg on the next edge; it is accepted in any state and regardless of en.
REQ-027 A wrap compare on the same edge as a period_load SHALL use the old period_reg; the new value applies from the following cycle.
REQ-028 busy SHALL equal (state==RUN) and SHALL have no combinational path from inputs.
REQ-029 All arithmetic SHALL be unsigned CNT_W bits; count SHALL never exceed max(period_reg, value held at a period decrease).

Reset
REQ-030 While rst_n=0, outputs SHALL be: count=0, tick=0, period_reg=DEFAULT_PERIOD, mode=periodic.
REQ-031 While rst_n=0, state SHALL be RUN if AUTOSTART=1 (busy=1), otherwise IDLE (busy=0).
REQ-032 Assertion of rst_n mid-count SHALL clear state immediately, without waiting for clk.
REQ-033 Release of rst_n SHALL be synchronised externally; the first edge after release SHALL be a normal count edge.

Verification
REQ-034 SHALL verify: AUTOSTART=1, DEFAULT_PERIOD=4, en=1 after reset -> tick pulses on edges 5, 10, 15; busy=1 throughout.
REQ-035 SHALL verify: AUTOSTART=0, period 3, start with one_shot=1 -> exactly one tick, 4 clocks after start, then busy=0 and count=0; no further ticks.
REQ-036 SHALL verify: count=8 with period 10, load period_in=5 -> wrap and tick on the edge after the load takes effect; next ticks every 6 clocks.
REQ-037 SHALL verify: en=0 for 7 cycles at count=2 -> count holds 2 and tick stays 0; after en=1, tick follows 1 clock later than the uninterrupted schedule... per cycle paused.
REQ-038 SHALL verify: start and stop asserted together in RUN -> IDLE, count=0, busy=0, no tick.
REQ-039 SHALL verify: period_reg=0 in periodic RUN -> tick continuously high; rst_n pulled low asynchronously mid-pattern -> tick=0 and count=0 immediately.
